// File: rtl/axi_lite_arb_pkg.sv
// axi_lite_arb_pkg: shared FSM states and constants for the AXI-Lite arbiter
package axi_lite_arb_pkg;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_e;
   localparam int          DEF_TIMEOUT = 256;
   localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;
endpackage

// File: rtl/axi_lite_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick starting just after last winner
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);
   logic found;
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         if (!found && req[(int'(last) + k) % N]) begin
            found = 1'b1;
            idx   = IW'((int'(last) + k) % N);
         end
      end
      grant[idx] = found;
   end
endmodule

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: round-robin funnel of N requesters onto one AXI-Lite master
module axi_lite_arbiter
   import axi_lite_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [NUM_REQ*32-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    req_grant,
   output logic [NUM_REQ-1:0]    req_done,
   output logic [31:0]           req_rdata,
   output logic                  req_err,
   output logic                  m_transfer,
   output logic                  m_write,
   output logic [31:0]           m_addr,
   output logic [31:0]           m_wdata,
   input  logic                  m_ready,
   input  logic [31:0]           m_rdata
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT);
   state_e             state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d, last_q, last_d, pick_idx;
   logic [NUM_REQ-1:0] pick_grant;
   logic               write_q, write_d, err_q, err_d;
   logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req   (req_valid),
      .last  (last_q),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      cnt_d   = '0;
      case (state_q)
         IDLE: if (|req_valid) begin
            idx_d   = pick_idx;
            last_d  = pick_idx;
            write_d = req_write[pick_idx];
            addr_d  = req_addr[int'(pick_idx)*32 +: 32];
            wdata_d = req_wdata[int'(pick_idx)*32 +: 32];
            state_d = ISSUE;
         end
         ISSUE: state_d = WAIT;
         WAIT: if (m_ready) begin
            rdata_d = m_rdata;
            err_d   = 1'b0;
            state_d = DONE;
         end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rdata_d = ERR_DATA;
            err_d   = 1'b1;
            state_d = DONE;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         DONE:  state_d = err_q ? DRAIN : IDLE;
         DRAIN: state_d = m_ready ? IDLE : DRAIN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         idx_q   <= '0;
         last_q  <= IW'(NUM_REQ - 1);
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // grant is combinational, so it is masked while reset holds the block
   assign req_grant  = (ARESETn && state_q == IDLE) ? pick_grant : '0;
   assign req_done   = (state_q == DONE) ? NUM_REQ'(1) << idx_q : '0;
   assign req_rdata  = rdata_q;
   assign req_err    = err_q;
   assign m_transfer = state_q == ISSUE;
   assign m_write    = write_q;
   assign m_addr     = addr_q;
   assign m_wdata    = wdata_q;
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed vectors with hand-computed expectations
module tb_axi_lite_arbiter;
   logic         ACLK = 1'b0;
   logic         ARESETn;
   logic [3:0]   req_valid, req_write, req_grant, req_done;
   logic [127:0] req_addr, req_wdata;
   logic [31:0]  req_rdata, m_addr, m_wdata, m_rdata;
   logic         req_err, m_transfer, m_write, m_ready;
   int           checks = 0;
   int           errors = 0;

   axi_lite_arbiter #(.NUM_REQ(4), .TIMEOUT(8)) dut (
      .ACLK       (ACLK),
      .ARESETn    (ARESETn),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_grant  (req_grant),
      .req_done   (req_done),
      .req_rdata  (req_rdata),
      .req_err    (req_err),
      .m_transfer (m_transfer),
      .m_write    (m_write),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .m_ready    (m_ready),
      .m_rdata    (m_rdata)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic txn(input string tag, input logic [3:0] valid, input int w, input int lat,
                      input logic [31:0] rd);
      @(negedge ACLK);
      req_valid = valid;
      #1 check({tag, "_grant"}, 32'(req_grant), 32'(1) << w);
      @(negedge ACLK);
      check({tag, "_xfer"}, 32'(m_transfer), 32'd1);
      check({tag, "_nogrant_issue"}, 32'(req_grant), 32'd0);
      repeat (lat - 1) @(negedge ACLK);
      @(negedge ACLK);
      m_ready = 1'b1;
      m_rdata = rd;
      check({tag, "_xfer_wait"}, 32'(m_transfer), 32'd0);
      @(negedge ACLK);
      m_ready = 1'b0;
      m_rdata = '0;
      #1 check({tag, "_done"}, 32'(req_done), 32'(1) << w);
      check({tag, "_rdata"}, req_rdata, rd);
      check({tag, "_err"}, 32'(req_err), 32'd0);
      check({tag, "_nogrant_done"}, 32'(req_grant), 32'd0);
   endtask

   initial begin
      ARESETn   = 1'b0;
      req_valid = 4'b1111;
      req_write = '0;
      req_addr  = {32'h40, 32'h30, 32'h20, 32'h10};
      req_wdata = '0;
      m_ready   = 1'b0;
      m_rdata   = '0;
      #12;
      check("rst_grant", 32'(req_grant), 32'd0);
      check("rst_done", 32'(req_done), 32'd0);
      check("rst_xfer", 32'(m_transfer), 32'd0);
      check("rst_addr", m_addr, 32'd0);
      check("rst_rdata", req_rdata, 32'd0);
      check("rst_err", 32'(req_err), 32'd0);
      @(negedge ACLK);
      ARESETn   = 1'b1;
      req_valid = '0;
      #1 check("idle_nogrant", 32'(req_grant), 32'd0);

      txn("rr0", 4'b1111, 0, 1, 32'h1111_0000);
      txn("rr1", 4'b1111, 1, 2, 32'h1111_0001);
      txn("rr2", 4'b1111, 2, 3, 32'h1111_0002);
      txn("rr3", 4'b1111, 3, 1, 32'h1111_0003);
      txn("rr4", 4'b1111, 0, 2, 32'h1111_0004);

      req_addr[31:0] = 32'h4;
      txn("rd", 4'b0001, 0, 2, 32'h1234_5678);
      check("rd_addr", m_addr, 32'h4);
      check("rd_write", 32'(m_write), 32'd0);
      @(negedge ACLK);
      req_valid = '0;
      #1 check("rd_done_clear", 32'(req_done), 32'd0);
      check("rd_hold", req_rdata, 32'h1234_5678);

      @(negedge ACLK);
      req_valid        = 4'b0100;
      req_write        = 4'b0100;
      req_addr[95:64]  = 32'h8;
      req_wdata[95:64] = 32'hA5A5_A5A5;
      #1 check("wr_grant", 32'(req_grant), 32'b0100);
      @(negedge ACLK);
      req_valid        = '0;
      req_write        = '0;
      req_addr[95:64]  = 32'hFFFF;
      req_wdata[95:64] = '0;
      #1 check("wr_xfer", 32'(m_transfer), 32'd1);
      check("wr_mwrite", 32'(m_write), 32'd1);
      check("wr_addr_issue", m_addr, 32'h8);
      check("wr_data_issue", m_wdata, 32'hA5A5_A5A5);
      @(negedge ACLK);
      @(negedge ACLK);
      m_ready = 1'b1;
      #1 check("wr_addr_wait", m_addr, 32'h8);
      check("wr_data_wait", m_wdata, 32'hA5A5_A5A5);
      check("wr_mwrite_wait", 32'(m_write), 32'd1);
      @(negedge ACLK);
      m_ready = 1'b0;
      #1 check("wr_done", 32'(req_done), 32'b0100);
      check("wr_err", 32'(req_err), 32'd0);

      txn("edge", 4'b0010, 1, 8, 32'hCAFE_0001);

      @(negedge ACLK);
      req_valid = 4'b0001;
      #1 check("to_grant", 32'(req_grant), 32'b0001);
      for (int c = 1; c <= 21; c++) begin
         @(negedge ACLK);
         if (c == 2) req_valid = 4'b1111;
         if (c == 21) m_ready = 1'b1;
         #1;
         if (c == 10) begin
            check("to_done", 32'(req_done), 32'b0001);
            check("to_err", 32'(req_err), 32'd1);
            check("to_rdata", req_rdata, 32'hDEAD_BEEF);
         end else begin
            check($sformatf("to_nodone_%0d", c), 32'(req_done), 32'd0);
         end
         if (c >= 2) check($sformatf("to_nogrant_%0d", c), 32'(req_grant), 32'd0);
         if (c >= 11) check($sformatf("drain_noxfer_%0d", c), 32'(m_transfer), 32'd0);
      end
      @(negedge ACLK);
      m_ready = 1'b0;
      #1 check("after_drain_grant", 32'(req_grant), 32'b0010);
      check("after_drain_nodone", 32'(req_done), 32'd0);
      check("err_hold", 32'(req_err), 32'd1);
      @(negedge ACLK);
      req_valid = '0;
      #1 check("after_drain_xfer", 32'(m_transfer), 32'd1);
      @(negedge ACLK);
      m_ready = 1'b1;
      m_rdata = 32'h77;
      @(negedge ACLK);
      m_ready = 1'b0;
      #1 check("after_drain_done", 32'(req_done), 32'b0010);
      check("after_drain_err", 32'(req_err), 32'd0);
      check("after_drain_rdata", req_rdata, 32'h77);

      @(negedge ACLK);
      req_addr[95:64] = 32'h30;
      req_write       = 4'b0100;
      req_valid       = 4'b0100;
      #1 check("mid_grant", 32'(req_grant), 32'b0100);
      @(negedge ACLK);
      req_valid = 4'b1111;
      @(negedge ACLK);
      #1 check("mid_addr", m_addr, 32'h30);
      ARESETn = 1'b0;
      #1 check("mid_rst_grant", 32'(req_grant), 32'd0);
      check("mid_rst_xfer", 32'(m_transfer), 32'd0);
      check("mid_rst_write", 32'(m_write), 32'd0);
      check("mid_rst_addr", m_addr, 32'd0);
      check("mid_rst_rdata", req_rdata, 32'd0);
      check("mid_rst_err", 32'(req_err), 32'd0);
      check("mid_rst_done", 32'(req_done), 32'd0);
      @(negedge ACLK);
      ARESETn   = 1'b1;
      req_valid = '0;
      txn("post_rst", 4'b1111, 0, 1, 32'h5555_AAAA);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
